// File: rtl/aq_djpeg_bitsched.sv
// Arbitrates the bitstream consume port between header parser and Huffman
// decoder, and sequences restart markers (align, RSTn check, DC reset).
module aq_djpeg_bitsched (
  input  logic        clk,
  input  logic        rst,
  input  logic        ImageEnable,
  input  logic        ProcessIdle,
  input  logic [31:0] DataOut,
  input  logic        DataOutEnable,
  input  logic        DataOutEnd,
  output logic        UseBit,
  output logic [6:0]  UseWidth,
  output logic        UseByte,
  output logic        UseWord,
  output logic        AlignByte,
  input  logic        HdrUseByte,
  input  logic        HdrUseWord,
  output logic        HdrReady,
  input  logic        HufUseBit,
  input  logic [6:0]  HufUseWidth,
  output logic        HufReady,
  input  logic [15:0] RestartInterval,
  input  logic        McuDone,
  output logic        McuHold,
  output logic        DcReset,
  output logic        RstError,
  output logic [2:0]  RstIndex
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ALIGN, S_WAITMRK, S_CHKMRK, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mcu_count, mcu_count_nxt;
  logic [16:0] mcu_inc;
  logic [2:0]  idx_nxt;
  logic        dc_nxt, err_nxt;
  logic        abort;
  logic [15:0] marker;

  // Only the upper half of the window can hold the marker we inspect.
  logic unused_low;
  assign unused_low = ^DataOut[15:0];

  assign marker  = DataOut[31:16];
  assign abort   = ProcessIdle | ~ImageEnable;
  assign mcu_inc = {1'b0, mcu_count} + 17'd1;
  assign McuHold = (state == S_ALIGN) || (state == S_WAITMRK) ||
                   (state == S_CHKMRK) || (state == S_DONE);

  always_comb begin
    state_nxt     = state;
    mcu_count_nxt = mcu_count;
    idx_nxt       = RstIndex;
    dc_nxt        = 1'b0;
    err_nxt       = 1'b0;
    UseBit        = 1'b0;
    UseWidth      = 7'd0;
    UseByte       = 1'b0;
    UseWord       = 1'b0;
    AlignByte     = 1'b0;
    HdrReady      = 1'b0;
    HufReady      = 1'b0;
    case (state)
      S_IDLE: begin
        HdrReady      = DataOutEnable;
        UseByte       = HdrReady & HdrUseByte;
        UseWord       = HdrReady & HdrUseWord & ~HdrUseByte;
        mcu_count_nxt = 16'd0;
        idx_nxt       = 3'd0;
        if (!abort) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        HufReady = DataOutEnable & ~McuHold;
        if (HufReady) begin
          UseBit   = HufUseBit;
          UseWidth = HufUseWidth;
        end
        if (DataOutEnd) begin
          state_nxt = S_DONE;
        end else if (McuDone) begin
          if (RestartInterval == 16'd0 || mcu_inc < {1'b0, RestartInterval}) begin
            mcu_count_nxt = mcu_inc[15:0];
          end else begin
            mcu_count_nxt = 16'd0;
            state_nxt     = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        AlignByte = DataOutEnable;
        if (DataOutEnable) state_nxt = S_WAITMRK;
      end
      S_WAITMRK: begin
        if (DataOutEnable) state_nxt = S_CHKMRK;
      end
      S_CHKMRK: begin
        // Window may still be blanked; hold here until it is valid.
        if (DataOutEnable) begin
          if (marker[15:3] == {8'hFF, 5'b11010}) begin
            UseWord   = 1'b1;
            dc_nxt    = 1'b1;
            err_nxt   = (marker[2:0] != RstIndex);
            idx_nxt   = marker[2:0] + 3'd1;
            state_nxt = S_SCAN;
          end else if (marker == 16'hFFD9) begin
            state_nxt = S_DONE;
          end else begin
            dc_nxt    = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = S_SCAN;
          end
        end
      end
      S_DONE: ;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt     = S_IDLE;
      mcu_count_nxt = 16'd0;
      idx_nxt       = 3'd0;
      dc_nxt        = 1'b0;
      err_nxt       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mcu_count <= 16'd0;
      RstIndex  <= 3'd0;
      DcReset   <= 1'b0;
      RstError  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcu_count <= mcu_count_nxt;
      RstIndex  <= idx_nxt;
      DcReset   <= dc_nxt;
      RstError  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_bitsched.sv
// Scoreboard bench for aq_djpeg_bitsched: expected consume/pulse events are
// queued as stimulus is driven and matched in order as the block emits them.
module tb_aq_djpeg_bitsched;

  logic        clk = 1'b0;
  logic        rst;
  logic        ImageEnable, ProcessIdle, DataOutEnable, DataOutEnd;
  logic [31:0] DataOut;
  logic        UseBit, UseByte, UseWord, AlignByte;
  logic [6:0]  UseWidth;
  logic        HdrUseByte, HdrUseWord, HdrReady;
  logic        HufUseBit, HufReady;
  logic [6:0]  HufUseWidth;
  logic [15:0] RestartInterval;
  logic        McuDone, McuHold, DcReset, RstError;
  logic [2:0]  RstIndex;

  always #5 clk = ~clk;

  aq_djpeg_bitsched dut (
    .clk(clk), .rst(rst), .ImageEnable(ImageEnable), .ProcessIdle(ProcessIdle),
    .DataOut(DataOut), .DataOutEnable(DataOutEnable), .DataOutEnd(DataOutEnd),
    .UseBit(UseBit), .UseWidth(UseWidth), .UseByte(UseByte), .UseWord(UseWord),
    .AlignByte(AlignByte), .HdrUseByte(HdrUseByte), .HdrUseWord(HdrUseWord),
    .HdrReady(HdrReady), .HufUseBit(HufUseBit), .HufUseWidth(HufUseWidth),
    .HufReady(HufReady), .RestartInterval(RestartInterval), .McuDone(McuDone),
    .McuHold(McuHold), .DcReset(DcReset), .RstError(RstError), .RstIndex(RstIndex)
  );

  int n_chk = 0, n_pass = 0;
  logic [11:0] exp_q[$];

  // Stream register model: window blanked the cycle after any consume.
  logic blank = 1'b0;
  logic en_req;
  assign DataOutEnable = en_req & ~blank;
  always @(posedge clk) blank <= UseBit | UseByte | UseWord | AlignByte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // event = {kind(1 bit,2 byte,3 word,4 align,7 multiple), width, dc, err}
  function automatic logic [11:0] ev(input logic [2:0] k, input logic [6:0] w,
                                     input logic dc, input logic err);
    return {k, w, dc, err};
  endfunction

  logic [2:0]  mk;
  logic [11:0] mo;
  int          nuse;
  always @(negedge clk) begin
    if (!rst) begin
      nuse = int'(UseBit) + int'(UseByte) + int'(UseWord) + int'(AlignByte);
      mk = 3'd0;
      if (nuse > 1)       mk = 3'd7;
      else if (UseBit)    mk = 3'd1;
      else if (UseByte)   mk = 3'd2;
      else if (UseWord)   mk = 3'd3;
      else if (AlignByte) mk = 3'd4;
      mo = {mk, (UseBit ? UseWidth : 7'd0), DcReset, RstError};
      if (mo != 12'd0) begin
        if (exp_q.size() == 0) chk("unexpected_event", {20'd0, mo}, 32'd0);
        else chk("event", {20'd0, mo}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reenter();
    ImageEnable = 1'b0; tick();
    ImageEnable = 1'b1; tick();
  endtask

  // Two MCUs (RestartInterval=2), then follow the marker sequence back to SCAN.
  task automatic restart(input logic [15:0] mrk, input logic [11:0] post_ev,
                         input logic use_word, input logic [2:0] exp_idx,
                         input string tag);
    int i;
    DataOut = {mrk, 16'h0000};
    exp_q.push_back(ev(3'd4, 7'd0, 1'b0, 1'b0));
    if (use_word) exp_q.push_back(ev(3'd3, 7'd0, 1'b0, 1'b0));
    exp_q.push_back(post_ev);
    McuDone = 1'b1; tick(); McuDone = 1'b0; tick();
    McuDone = 1'b1; tick(); McuDone = 1'b0;
    i = 0;
    do begin tick(); i++; end while (McuHold && i < 20);
    chk({tag, "_timeout"}, {31'd0, (i >= 20)}, 32'd0);
    tick(); tick();
    chk(tag, {29'd0, RstIndex}, {29'd0, exp_idx});
  endtask

  initial begin
    logic hold_seen;
    rst = 1'b1; ImageEnable = 1'b0; ProcessIdle = 1'b0; DataOut = '0;
    DataOutEnd = 1'b0; HdrUseByte = 1'b0; HdrUseWord = 1'b0; HufUseBit = 1'b0;
    HufUseWidth = '0; RestartInterval = '0; McuDone = 1'b0; en_req = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", {20'd0, McuHold, DcReset, RstError, UseBit, UseByte, UseWord,
                       AlignByte, HufReady, UseWidth == 7'd0 ? 1'b0 : 1'b1, RstIndex}, 32'd0);
    chk("reset_hdrready", {31'd0, HdrReady}, 32'd1);
    tick(); rst = 1'b0;

    // header mode
    HdrUseByte = 1'b1; HdrUseWord = 1'b1;
    exp_q.push_back(ev(3'd2, 7'd0, 1'b0, 1'b0));
    @(negedge clk);
    chk("hdr_both_no_word", {31'd0, UseWord}, 32'd0);
    tick(); HdrUseByte = 1'b0; HdrUseWord = 1'b0;
    tick();
    en_req = 1'b0; HdrUseWord = 1'b1;
    @(negedge clk);
    chk("hdr_noen_use", {30'd0, UseByte, UseWord}, 32'd0);
    chk("hdr_noen_ready", {31'd0, HdrReady}, 32'd0);
    tick(); en_req = 1'b1;
    exp_q.push_back(ev(3'd3, 7'd0, 1'b0, 1'b0));
    tick(); HdrUseWord = 1'b0;
    tick();

    // scan, restart disabled
    ImageEnable = 1'b1; tick();
    HufUseBit = 1'b1; HufUseWidth = 7'd13;
    exp_q.push_back(ev(3'd1, 7'd13, 1'b0, 1'b0));
    @(negedge clk);
    chk("huf_width", {25'd0, UseWidth}, 32'd13);
    chk("huf_ready", {31'd0, HufReady}, 32'd1);
    tick(); HufUseBit = 1'b0; tick();
    hold_seen = 1'b0;
    repeat (100) begin
      McuDone = 1'b1; tick(); McuDone = 1'b0;
      @(negedge clk);
      if (McuHold) hold_seen = 1'b1;
      tick();
    end
    chk("ri0_no_hold", {31'd0, hold_seen}, 32'd0);

    // restart interval 2
    RestartInterval = 16'd2;
    reenter();
    restart(16'hFFD0, ev(3'd0, 7'd0, 1'b1, 1'b0), 1'b1, 3'd1, "idx_ffd0");
    restart(16'hFFD1, ev(3'd0, 7'd0, 1'b1, 1'b0), 1'b1, 3'd2, "idx_ffd1");
    reenter();
    chk("reenter_idx", {29'd0, RstIndex}, 32'd0);
    restart(16'hFFD3, ev(3'd0, 7'd0, 1'b1, 1'b1), 1'b1, 3'd4, "idx_mismatch");
    restart(16'h1234, ev(3'd0, 7'd0, 1'b1, 1'b1), 1'b0, 3'd4, "idx_garbage");

    // EOI marker at restart point
    DataOut = 32'hFFD9_0000;
    exp_q.push_back(ev(3'd4, 7'd0, 1'b0, 1'b0));
    McuDone = 1'b1; tick(); McuDone = 1'b0; tick();
    McuDone = 1'b1; tick(); McuDone = 1'b0;
    repeat (6) tick();
    chk("done_hold", {31'd0, McuHold}, 32'd1);
    chk("done_idx", {29'd0, RstIndex}, 32'd4);
    HufUseBit = 1'b1; HufUseWidth = 7'd5;
    repeat (4) tick();
    @(negedge clk);
    chk("done_huf_ready", {31'd0, HufReady}, 32'd0);
    tick(); HufUseBit = 1'b0; ProcessIdle = 1'b1;
    tick();
    @(negedge clk);
    chk("pidle_hold", {31'd0, McuHold}, 32'd0);
    chk("pidle_hdrready", {31'd0, HdrReady}, 32'd1);
    tick(); ProcessIdle = 1'b0; tick();

    // reset while waiting for the marker
    RestartInterval = 16'd1;
    DataOut = 32'hFFD4_0000;
    exp_q.push_back(ev(3'd4, 7'd0, 1'b0, 1'b0));
    McuDone = 1'b1; tick(); McuDone = 1'b0;
    tick();
    en_req = 1'b0; HufUseBit = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("waitmrk_hold", {31'd0, McuHold}, 32'd1);
    chk("hold_huf_ignored", {31'd0, UseBit}, 32'd0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_waitmrk_outs", {21'd0, McuHold, DcReset, RstError, UseBit, UseByte, UseWord,
                             AlignByte, HdrReady, RstIndex}, 32'd0);
    tick(); HufUseBit = 1'b0; en_req = 1'b1;
    tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_bitsched.md
# aq_djpeg_bitsched

Consumption scheduler for the JPEG bitstream register, which supplies a 32-bit left-aligned window (DataOut/DataOutEnable) and takes use commands (UseBit/UseWidth, UseByte, UseWord, AlignByte). The block arbitrates that single consume port between the header parser (byte/word granularity, outside scan) and the Huffman decoder (bit granularity, inside scan). It also runs the restart-interval sequence: count MCUs, byte-align, check and consume the RSTn marker, and pulse a DC-predictor reset.

## Interface

- No parameters.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ImageEnable  in  1  scan active (SOS parsed); 0 = header mode
- ProcessIdle  in  1  decoder idle; returns block to IDLE
- DataOut  in  32  bitstream window, MSB = next bit
- DataOutEnable  in  1  window valid this cycle
- DataOutEnd  in  1  EOI seen by the stream register
- UseBit  out  1  consume UseWidth bits
- UseWidth  out  7  bit count for UseBit (1..32)
- UseByte  out  1  consume 8 bits
- UseWord  out  1  consume 16 bits
- AlignByte  out  1  drop bits to next byte boundary
- HdrUseByte  in  1  header parser byte request
- HdrUseWord  in  1  header parser word request
- HdrReady  out  1  header requests accepted this cycle
- HufUseBit  in  1  Huffman bit request
- HufUseWidth  in  7  Huffman bit count
- HufReady  out  1  Huffman requests accepted this cycle
- RestartInterval  in  16  DRI value; 0 = restart disabled
- McuDone  in  1  one-cycle pulse, last bit of an MCU consumed
- McuHold  out  1  MCU sequencer must not start next MCU
- DcReset  out  1  one-cycle pulse, clear DC predictors
- RstError  out  1  one-cycle pulse, marker sequence error
- RstIndex  out  3  expected RSTn index

## Operation

- States: IDLE (header), SCAN, ALIGN, WAITMRK, CHKMRK, DONE.
- IDLE: HdrReady = DataOutEnable. HdrUseByte/HdrUseWord forwarded combinationally to UseByte/UseWord only while HdrReady; both high → byte only. ImageEnable=1 → SCAN, McuCount=0, RstIndex=0.
- SCAN: HufReady = DataOutEnable & ~McuHold. While HufReady, UseBit=HufUseBit, UseWidth=HufUseWidth; otherwise UseBit=0 and UseWidth=0. Requests without ready are ignored (dropped, no consumption).
- McuDone in SCAN: if RestartInterval==0 or McuCount+1 < RestartInterval → McuCount++ (16-bit, stay SCAN). Else McuCount=0, → ALIGN. McuDone coinciding with HufUseBit: the bit use is forwarded, then transition.
- McuHold = 1 in ALIGN, WAITMRK, CHKMRK, DONE.
- ALIGN: assert AlignByte for exactly one cycle once DataOutEnable=1, → WAITMRK.
- WAITMRK: wait until DataOutEnable=1, → CHKMRK.
- CHKMRK (one cycle, DataOutEnable=1), evaluated on DataOut[31:16]:
  - == {8'hFF, 5'b11010, RstIndex}: UseWord=1, DcReset=1, RstIndex+1 (wraps 7→0), → SCAN.
  - == FFD0..FFD7 with other index n: UseWord=1, DcReset=1, RstError=1, RstIndex=n+1, → SCAN.
  - == FFD9: RstError=0, no consume, → DONE.
  - else: RstError=1, DcReset=1, no consume, → SCAN.
- DONE: no uses issued.
- From any state: ProcessIdle=1 or ImageEnable=0 → IDLE, counters cleared. DataOutEnd=1 in SCAN → DONE.
- At most one of UseBit/UseByte/UseWord/AlignByte is high in any cycle.

## Timing

- Reset (synchronous, priority over all): state IDLE, McuCount=0, RstIndex=0. All outputs 0, except HdrReady, which follows DataOutEnable combinationally.
- Use outputs are combinational from requester inputs and state. No added latency: a request accepted in cycle N is seen by the stream register at edge N+1.
- The stream register blanks DataOutEnable for at least one cycle after any use. Ready therefore drops in that cycle with no extra logic.
- DcReset and RstError are registered one-cycle pulses, asserted the cycle after CHKMRK.
- Restart overhead: McuDone at N → ALIGN at N+1 → AlignByte when DataOutEnable=1 → CHKMRK no earlier than 2 cycles later → SCAN.

## Test plan

- Header mode, DataOutEnable=1: HdrUseByte+HdrUseWord together → UseByte=1, UseWord=0. With DataOutEnable=0 → no use output.
- SCAN, RestartInterval=0: 100 McuDone pulses → never ALIGN, McuHold stays 0. HufUseWidth=13 → UseWidth=13.
- RestartInterval=2, stream …FFD0…FFD1: 2nd McuDone → AlignByte once, UseWord at CHKMRK, DcReset pulse, RstIndex 0→1. Repeat → RstIndex 2.
- Expected FFD0, stream FFD3 → UseWord, DcReset, RstError pulses, RstIndex=4. Stream 1234 at CHKMRK → RstError, no UseWord.
- FFD9 at CHKMRK → DONE, McuHold=1, no further uses. ProcessIdle → IDLE.
- rst asserted in WAITMRK → next cycle IDLE, all outputs 0, RstIndex=0. HufUseBit during hold → ignored.
